// File: rtl/instruction_writer.sv
// instruction_writer: serialises a 48-bit instruction ({imm, ins}) into byte memory as six
// little-endian bytes at base..base+5, one byte per accepted memory cycle.
// Optional feature macro: INSW_AUTOINC_EN. When defined, a request without req_seek
// continues at the address following the previous instruction (next_base).
module instruction_writer #(
   parameter int unsigned AW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [15:0]   req_ins,
   input  logic [31:0]   req_imm,
   input  logic          req_seek,
   output logic [AW-1:0] m_addr,
   output logic [7:0]    m_wdata,
   output logic          m_we,
   input  logic          m_ready,
   output logic          busy,
   output logic          done,
   output logic [31:0]   insn_count
);

   typedef enum logic {StIdle, StWrite} state_e;

   state_e        state;
   logic [2:0]    idx;
   logic [47:0]   hold;
   logic          last_beat;
   logic          accept;
   logic [AW-1:0] base_sel;

   // Byte i of the holding register, little-endian.
   function automatic logic [7:0] byte_at(input logic [47:0] w, input logic [2:0] i);
      logic [7:0] b;
      b = 8'h00;
      unique case (i)
         3'd0:    b = w[7:0];
         3'd1:    b = w[15:8];
         3'd2:    b = w[23:16];
         3'd3:    b = w[31:24];
         3'd4:    b = w[39:32];
         3'd5:    b = w[47:40];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Final byte is leaving this cycle; a new request may be taken without a bubble.
   assign last_beat = (state == StWrite) && (idx == 3'd5) && m_ready;
   assign req_ready = (state == StIdle) || last_beat;
   assign accept    = req_valid && req_ready;
   assign busy      = (state == StWrite);

`ifdef INSW_AUTOINC_EN
   logic [AW-1:0] next_base;

   // In the final-byte cycle next_base is not yet updated, so forward base+6 (= m_addr+1).
   always_comb begin
      base_sel = req_addr;
      if (!req_seek) begin
         base_sel = last_beat ? (m_addr + AW'(1)) : next_base;
      end
   end

   // Address following the most recently completed instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         next_base <= '0;
      end else if (last_beat) begin
         next_base <= m_addr + AW'(1);
      end
   end
`else
   logic unused_seek;
   assign unused_seek = req_seek;

   // Every request supplies its own base address.
   always_comb begin
      base_sel = req_addr;
   end
`endif

   // Control FSM with registered memory-side outputs and completion bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         idx        <= 3'd0;
         hold       <= '0;
         m_addr     <= '0;
         m_wdata    <= 8'h00;
         m_we       <= 1'b0;
         done       <= 1'b0;
         insn_count <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            state   <= StWrite;
            idx     <= 3'd0;
            hold    <= {req_imm, req_ins};
            m_addr  <= base_sel;
            m_wdata <= req_ins[7:0];
            m_we    <= 1'b1;
         end else if ((state == StWrite) && m_ready) begin
            if (idx == 3'd5) begin
               state <= StIdle;
               idx   <= 3'd0;
               m_we  <= 1'b0;
            end else begin
               idx     <= idx + 3'd1;
               m_addr  <= m_addr + AW'(1);
               m_wdata <= byte_at(hold, idx + 3'd1);
            end
         end
         if (last_beat) begin
            done       <= 1'b1;
            insn_count <= insn_count + 32'd1;
         end
      end
   end

   // A stalled byte must not change until memory takes it.
   a_stall_stable : assert property (@(posedge clk) disable iff (rst)
      (m_we && !m_ready) |=> ($stable(m_addr) && $stable(m_wdata) && m_we));

   // The byte index never leaves 0..5.
   a_idx_range : assert property (@(posedge clk) disable iff (rst) idx <= 3'd5);

endmodule
